// File: rtl/imem_pkg.sv
// Shared types and sizes for the instruction-memory boot loader.
package imem_pkg;

  localparam int IMEM_DEPTH  = 32;
  localparam int IMEM_ADDR_W = 5;
  localparam int WORD_W      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    RUN   = 2'd3
  } state_t;

endpackage

// File: rtl/word_packer.sv
// Packs accepted bytes MSB-first into a 32-bit word; word_full flags the accept completing it.
// Zero latency: word_next already includes the byte being accepted this cycle.
module word_packer
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_data,
  output logic [WORD_W-1:0] word_next,
  output logic              word_full
);

  // Only the three earlier bytes need storage; the last one comes straight from byte_data.
  logic [1:0]        byte_cnt;
  logic [WORD_W-9:0] word_q;

  assign word_next = {word_q, byte_data};
  assign word_full = accept && (byte_cnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      word_q   <= word_next[WORD_W-9:0];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory one word per 5 cycles, then releases the CPU.
// Backpressure: byte_ready is high only in LOAD; a stalled byte_valid simply holds progress.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [31:0]       pc_in,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  state_t            state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] widx;
  logic              accept;
  logic              len_legal;
  logic              load_go;
  logic              word_full;
  logic [WORD_W-1:0] word_next;
  logic              unused_pc;

  // PC is a byte address; the memory is word indexed.
  assign mem_raddr = pc_in[ADDR_W+1:2];
  assign unused_pc = ^{pc_in[31:ADDR_W+2], pc_in[1:0]};

  assign accept    = byte_valid && byte_ready;
  assign len_legal = (prog_len != '0) && (int'(prog_len) <= DEPTH);
  assign load_go   = start && len_legal && ((state == IDLE) || (state == RUN));

  word_packer u_packer (
    .clk       (clk),
    .rst       (reset),
    .clear     (load_go),
    .accept    (accept),
    .byte_data (byte_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      byte_ready   <= 1'b0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      cpu_run      <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      len_q        <= '0;
      widx         <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (start) begin
            if (len_legal) begin
              state        <= LOAD;
              len_q        <= prog_len;
              widx         <= '0;
              words_loaded <= '0;
              error        <= 1'b0;
              byte_ready   <= 1'b1;
              busy         <= 1'b1;
              cpu_run      <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (word_full) begin
            state      <= WRITE;
            byte_ready <= 1'b0;
            mem_we     <= 1'b1;
            mem_waddr  <= widx;
            mem_wdata  <= word_next;
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + (ADDR_W+1)'(1);
          if ({1'b0, widx} == len_q - (ADDR_W+1)'(1)) begin
            state   <= RUN;
            cpu_run <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state      <= LOAD;
            widx       <= widx + ADDR_W'(1);
            byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector tables, directed corner sequences and randomized loads.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  prog_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] pc_in;
  logic [4:0]  mem_raddr;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_run;
  logic        busy;
  logic        error;
  logic [5:0]  words_loaded;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t wq[$];

  typedef struct { logic [31:0] pc; logic [4:0] raddr; } pc_vec_t;
  typedef struct { logic [5:0] len; logic err; } len_vec_t;
  pc_vec_t  pcv[6];
  len_vec_t lenv[4];

  logic [7:0] prog [128];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .prog_len     (prog_len),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .pc_in        (pc_in),
    .mem_raddr    (mem_raddr),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .cpu_run      (cpu_run),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  // Every cycle with mem_we high is one write; negedge sees each exactly once.
  always @(negedge clk) begin
    if (mem_we) wq.push_back('{mem_waddr, mem_wdata});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [5:0] len);
    start    = 1'b1;
    prog_len = len;
    step();
    start = 1'b0;
  endtask

  task automatic fill_random(input int nbytes);
    for (int i = 0; i < nbytes; i++) prog[i] = 8'($urandom);
  endtask

  // mode 0: back-to-back, 1: valid toggles each cycle, 2: random valid.
  // poke injects a start pulse mid-load, which must be ignored.
  task automatic run_load(input int len, input int mode, input bit poke);
    int  idx;
    int  edges;
    bit  acc;
    logic [31:0] exp_d;
    idx = 0;
    wq.delete();
    byte_valid = 1'b0;
    pulse_start(6'(len));
    chk("start_busy", {31'b0, busy}, 32'd1);
    chk("start_ready", {31'b0, byte_ready}, 32'd1);
    chk("start_cpu_run", {31'b0, cpu_run}, 32'd0);
    chk("start_err_clr", {31'b0, error}, 32'd0);
    edges = 1;
    while (!cpu_run && edges < 5 * len + 200) begin
      if (idx >= 4 * len)  byte_valid = 1'b0;
      else if (mode == 0)  byte_valid = 1'b1;
      else if (mode == 1)  byte_valid = ((edges % 2) == 1);
      else                 byte_valid = 1'($urandom_range(0, 1));
      byte_data = byte_valid ? prog[idx] : 8'($urandom);
      if (poke && edges == 7) begin
        start    = 1'b1;
        prog_len = 6'($urandom_range(0, 63));
      end
      if (mem_we) chk("ready_low_in_write", {31'b0, byte_ready}, 32'd0);
      acc = byte_valid && byte_ready;
      step();
      start = 1'b0;
      edges++;
      if (acc) idx++;
    end
    byte_valid = 1'b0;
    if (mode == 0) chk("run_latency", 32'(edges), 32'(5 * len + 1));
    chk("cpu_run_up", {31'b0, cpu_run}, 32'd1);
    chk("busy_done", {31'b0, busy}, 32'd0);
    chk("error_after_load", {31'b0, error}, 32'd0);
    chk("words_loaded", {26'b0, words_loaded}, 32'(len));
    chk("bytes_consumed", 32'(idx), 32'(4 * len));
    chk("write_count", 32'(wq.size()), 32'(len));
    for (int i = 0; i < len; i++) begin
      exp_d = {prog[4*i], prog[4*i+1], prog[4*i+2], prog[4*i+3]};
      if (i < wq.size()) begin
        chk("waddr", {27'b0, wq[i].a}, 32'(i));
        chk("wdata", wq[i].d, exp_d);
      end
    end
  endtask

  initial begin
    int n;
    int wsz;
    logic [31:0] pc;

    pcv[0] = '{32'h0000_000C, 5'd3};
    pcv[1] = '{32'h0000_0000, 5'd0};
    pcv[2] = '{32'h0000_007C, 5'd31};
    pcv[3] = '{32'h0000_0080, 5'd0};
    pcv[4] = '{32'hFFFF_FFFF, 5'd31};
    pcv[5] = '{32'h0000_0013, 5'd4};
    lenv[0] = '{6'd0,  1'b1};
    lenv[1] = '{6'd33, 1'b1};
    lenv[2] = '{6'd40, 1'b1};
    lenv[3] = '{6'd63, 1'b1};

    reset = 1'b1; start = 1'b0; prog_len = '0; byte_valid = 1'b0;
    byte_data = '0; pc_in = '0;
    repeat (3) step();
    reset = 1'b0;
    repeat (10) step();

    chk("rst_cpu_run", {31'b0, cpu_run}, 32'd0);
    chk("rst_ready", {31'b0, byte_ready}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_words", {26'b0, words_loaded}, 32'd0);
    chk("rst_waddr", {27'b0, mem_waddr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("no_writes_idle", 32'(wq.size()), 32'd0);

    for (int i = 0; i < 6; i++) begin
      pc_in = pcv[i].pc;
      #1;
      chk("raddr_table", {27'b0, mem_raddr}, {27'b0, pcv[i].raddr});
    end

    // Illegal lengths in IDLE: flag error, stay idle, write nothing.
    for (int i = 0; i < 4; i++) begin
      pulse_start(lenv[i].len);
      chk("idle_bad_len_err", {31'b0, error}, {31'b0, lenv[i].err});
      chk("idle_bad_len_busy", {31'b0, busy}, 32'd0);
      chk("idle_bad_len_ready", {31'b0, byte_ready}, 32'd0);
    end
    step();
    chk("idle_bad_len_nowr", 32'(wq.size()), 32'd0);

    prog[0] = 8'h20; prog[1] = 8'h08; prog[2] = 8'h00; prog[3] = 8'h05;
    prog[4] = 8'h01; prog[5] = 8'h09; prog[6] = 8'h50; prog[7] = 8'h20;
    run_load(2, 0, 1'b0);
    if (wq.size() == 2) begin
      chk("w0_const", wq[0].d, 32'h2008_0005);
      chk("w1_const", wq[1].d, 32'h0109_5020);
    end else begin
      chk("w_const_count", 32'(wq.size()), 32'd2);
    end
    run_load(2, 1, 1'b0);

    // Bytes offered in RUN are not consumed.
    wsz = wq.size();
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    repeat (3) begin
      step();
      chk("run_ready_low", {31'b0, byte_ready}, 32'd0);
    end
    byte_valid = 1'b0;
    chk("run_no_write", 32'(wq.size()), 32'(wsz));
    chk("run_still_run", {31'b0, cpu_run}, 32'd1);

    // Illegal start in RUN: error set, CPU keeps running.
    pulse_start(6'd45);
    step();
    chk("run_bad_err", {31'b0, error}, 32'd1);
    chk("run_bad_cpu", {31'b0, cpu_run}, 32'd1);
    chk("run_bad_busy", {31'b0, busy}, 32'd0);

    // Reset after 6 bytes of a 3-word load.
    fill_random(12);
    wq.delete();
    pulse_start(6'd3);
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      byte_valid = 1'b1;
      byte_data  = prog[n];
      if (byte_ready) begin
        step();
        n++;
      end else begin
        step();
      end
    end
    byte_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", {31'b0, byte_ready}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_cpu", {31'b0, cpu_run}, 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("mid_rst_wcount", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) begin
      chk("mid_rst_waddr", {27'b0, wq[0].a}, 32'd0);
      chk("mid_rst_wdata", wq[0].d, {prog[0], prog[1], prog[2], prog[3]});
    end
    fill_random(4);
    run_load(1, 0, 1'b0);

    // Full-depth reload from RUN, with a stray start mid-load.
    fill_random(128);
    run_load(32, 0, 1'b1);

    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 8);
      fill_random(4 * n);
      run_load(n, 2, 1'($urandom_range(0, 1)));
      pc = $urandom;
      pc_in = pc;
      #1;
      chk("raddr_rand", {27'b0, mem_raddr}, (pc / 4) % 32);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time controller for the 32-word instruction memory.
- Accepts a program as a byte stream over a valid/ready handshake, packs each 4 bytes big-endian into a 32-bit word, and issues one write per word into the memory.
- Holds the CPU stopped (cpu_run=0) until the programmed word count has been written, then releases it.
- Maps the CPU's byte-addressed PC onto the memory's word read index.

Parameters:
- DEPTH, 32, number of instruction words in memory.
- ADDR_W, 5, word index width (log2 DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  single-cycle pulse; begins a load of prog_len words.
- prog_len  in  ADDR_W+1  number of words to load; legal range 1..DEPTH.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  program byte; first byte of each word is its MSB.
- byte_ready  out  1  loader accepts a byte this cycle.
- pc_in  in  32  CPU program counter, byte address.
- mem_raddr  out  ADDR_W  read index to memory = pc_in[ADDR_W+1:2]; combinational, valid in every state.
- mem_we  out  1  write strobe, one cycle per word.
- mem_waddr  out  ADDR_W  write index.
- mem_wdata  out  32  assembled word.
- cpu_run  out  1  CPU may execute; 0 means CPU held.
- busy  out  1  load in progress (LOAD or WRITE).
- error  out  1  sticky illegal prog_len flag.
- words_loaded  out  ADDR_W+1  count of words written in the current or last load.

Behaviour:
- Reset values: state=IDLE; byte_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_run=0, busy=0, error=0, words_loaded=0, byte counter=0.
- Memory contents are not cleared by reset.
- States: IDLE, LOAD, WRITE, RUN.
- IDLE:
  - start with 1<=prog_len<=DEPTH: latch prog_len, clear byte counter, word index, words_loaded and error; go to LOAD.
  - start with prog_len=0 or prog_len>DEPTH: error=1, stay IDLE.
- LOAD:
  - byte_ready=1, busy=1.
  - A byte is accepted when byte_valid&&byte_ready. Accepted bytes fill the assembly register MSB-first: byte 0 -> [31:24], byte 3 -> [7:0].
  - byte_valid low stalls indefinitely with no timeout; the byte counter holds.
  - On accepting the 4th byte, go to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_waddr=word index, mem_wdata=assembled word, byte_ready=0, busy=1.
  - words_loaded increments on exit.
  - If word index==len-1: go to RUN. Otherwise increment word index and return to LOAD.
- RUN:
  - cpu_run=1, busy=0, byte_ready=0.
  - start with legal prog_len: cpu_run drops on the next cycle, go to LOAD (reload).
  - start with illegal prog_len: error=1, remain in RUN.
- start during LOAD or WRITE is ignored; error is unchanged.
- byte_valid outside LOAD is ignored; no byte is consumed.
- mem_we is never asserted outside WRITE. There is at most one write per 5 cycles (4 accept cycles + 1 write).
- Minimum load time for N words: 5N cycles after the first LOAD cycle. cpu_run rises in the cycle after the final WRITE.
- Reset asserted mid-load: immediate return to IDLE with cpu_run=0. Partially written memory is retained. A new start is required.
- Word index never wraps, because len<=DEPTH is enforced at start.

Decomposition:
- Shared package imem_pkg:
  - state enum (IDLE, LOAD, WRITE, RUN);
  - IMEM_DEPTH=32;
  - IMEM_ADDR_W=5;
  - WORD_W=32.
- One natural sub-module: word_packer (byte counter plus 32-bit shift/assembly register, with accept and clear inputs and a word_full output). The FSM remains in imem_loader.

Test Plan:
- Reset then idle 10 cycles -> cpu_run=0, byte_ready=0, mem_we=0, error=0, mem_raddr follows pc_in (pc_in=0x0000000C -> mem_raddr=3).
- start, prog_len=2; bytes 0x20,0x08,0x00,0x05,0x01,0x09,0x50,0x20 streamed back-to-back:
  - first mem_we: waddr=0, wdata=0x20080005;
  - second mem_we: waddr=1, wdata=0x01095020;
  - cpu_run=1 in cycle 11 after LOAD entry; words_loaded=2.
- Same load with byte_valid toggling 1/0 each cycle -> identical writes, no dropped or duplicated bytes; byte_ready=0 during each WRITE cycle.
- start with prog_len=0, then with prog_len=33 -> error=1, state stays IDLE, no mem_we. A following start with prog_len=1 clears error.
- Reset asserted after 6 bytes of a prog_len=3 load:
  - immediately byte_ready=0, busy=0, cpu_run=0;
  - only waddr=0 was written;
  - a fresh start with prog_len=1 loads correctly.
- In RUN, start with prog_len=32 -> cpu_run=0 next cycle; 128 bytes produce writes to addresses 0..31 in order, then cpu_run=1; a start pulse during the load is ignored.
